// File: rtl/dual_issue_queue.sv
// Circular RV32 instruction queue feeding two registered issue slots, with hazard-aware pairing.
// Define ISSUE_STATS_EN to add the stat_dual / stat_single issue counters.

module diq_decode (
    input  logic [31:0] instr_i,
    output logic        writes_o,
    output logic        uses_rs1_o,
    output logic        uses_rs2_o,
    output logic        ctrl_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o
);
    logic [6:0] op;
    logic       unused_bits;

    assign op          = instr_i[6:0];
    assign rd_o        = instr_i[11:7];
    assign rs1_o       = instr_i[19:15];
    assign rs2_o       = instr_i[24:20];
    assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

    always_comb begin
        writes_o   = 1'b0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        ctrl_o     = 1'b0;
        case (op)
            7'b0110011: begin writes_o = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            7'b0010011: begin writes_o = 1'b1; uses_rs1_o = 1'b1; end
            7'b0000011: begin writes_o = 1'b1; uses_rs1_o = 1'b1; end
            7'b0110111: writes_o = 1'b1;
            7'b0010111: writes_o = 1'b1;
            7'b1101111: begin writes_o = 1'b1; ctrl_o = 1'b1; end
            7'b1100111: begin writes_o = 1'b1; uses_rs1_o = 1'b1; ctrl_o = 1'b1; end
            7'b0100011: begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            7'b1100011: begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; ctrl_o = 1'b1; end
            default: ;
        endcase
        // x0 is never a real destination, so it creates no hazard
        if (instr_i[11:7] == 5'd0) writes_o = 1'b0;
    end
endmodule

module dual_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int DUAL_ISSUE = 1,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             stall,
    input  logic             flush,
    output logic             slot0_valid,
    output logic [31:0]      slot0_instr,
    output logic             slot1_valid,
    output logic [31:0]      slot1_instr,
`ifdef ISSUE_STATS_EN
    output logic [31:0]      stat_dual,
    output logic [31:0]      stat_single,
`endif
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
    logic [31:0]      s0_ins_q, s0_ins_d, s1_ins_q, s1_ins_d;

    logic [1:0][31:0] cand;
    logic [1:0]       wr, u1, u2, ct;
    logic [1:0][4:0]  rd, rs1, rs2;
    logic             dep, issue0, issue1, advance, push;
    logic [1:0]       pop_n;

    assign cand[0] = mem_q[head_q];
    assign cand[1] = mem_q[head_q + PTR_W'(1)];

    for (genvar g = 0; g < 2; g++) begin : g_dec
        diq_decode u_dec (
            .instr_i   (cand[g]),
            .writes_o  (wr[g]),
            .uses_rs1_o(u1[g]),
            .uses_rs2_o(u2[g]),
            .ctrl_o    (ct[g]),
            .rd_o      (rd[g]),
            .rs1_o     (rs1[g]),
            .rs2_o     (rs2[g])
        );
    end

    assign dep = wr[0] && ((u1[1] && rs1[1] == rd[0]) ||
                           (u2[1] && rs2[1] == rd[0]) ||
                           (wr[1] && rd[1]  == rd[0]));

    assign issue0   = (count_q != '0);
    assign issue1   = (DUAL_ISSUE != 0) && (count_q > CNT_W'(1)) && !ct[0] && !dep;
    assign advance  = !stall && !flush;
    assign in_ready = (count_q != CNT_W'(DEPTH));
    // Zero words are accepted on the handshake but never stored
    assign push     = in_valid && in_ready && (in_instr != 32'h0);
    assign pop_n    = advance ? ({1'b0, issue0} + {1'b0, issue1}) : 2'd0;

    always_comb begin
        head_d   = head_q + PTR_W'(pop_n);
        tail_d   = tail_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop_n);
        s0_vld_d = s0_vld_q;
        s0_ins_d = s0_ins_q;
        s1_vld_d = s1_vld_q;
        s1_ins_d = s1_ins_q;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            s0_vld_d = 1'b0;
            s0_ins_d = 32'h0;
            s1_vld_d = 1'b0;
            s1_ins_d = 32'h0;
        end else if (advance) begin
            s0_vld_d = issue0;
            s0_ins_d = issue0 ? cand[0] : 32'h0;
            s1_vld_d = issue1;
            s1_ins_d = issue1 ? cand[1] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= in_instr;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            s0_vld_q <= 1'b0;
            s0_ins_q <= 32'h0;
            s1_vld_q <= 1'b0;
            s1_ins_q <= 32'h0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            s0_vld_q <= s0_vld_d;
            s0_ins_q <= s0_ins_d;
            s1_vld_q <= s1_vld_d;
            s1_ins_q <= s1_ins_d;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual_q, stat_single_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stat_dual_q   <= 32'h0;
            stat_single_q <= 32'h0;
        end else if (advance && issue0) begin
            if (issue1) stat_dual_q   <= stat_dual_q + 32'd1;
            else        stat_single_q <= stat_single_q + 32'd1;
        end
    end

    assign stat_dual   = stat_dual_q;
    assign stat_single = stat_single_q;
`endif

    assign slot0_valid = s0_vld_q;
    assign slot0_instr = s0_ins_q;
    assign slot1_valid = s1_vld_q;
    assign slot1_instr = s1_ins_q;
    assign count       = count_q;
endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: dual-issue main instance plus a single-issue instance on shared inputs.

module tb_dual_issue_queue;
    logic        clk = 1'b0;
    logic        n_rst, in_valid, stall, flush;
    logic [31:0] in_instr;

    logic        in_ready, slot0_valid, slot1_valid;
    logic [31:0] slot0_instr, slot1_instr;
    logic [3:0]  count;
    logic        in_ready_s, slot0_valid_s, slot1_valid_s;
    logic [31:0] slot0_instr_s, slot1_instr_s;
    logic [3:0]  count_s;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual, stat_single, stat_dual_s, stat_single_s;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(8), .DUAL_ISSUE(1)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .stall(stall), .flush(flush),
        .slot0_valid(slot0_valid), .slot0_instr(slot0_instr),
        .slot1_valid(slot1_valid), .slot1_instr(slot1_instr),
`ifdef ISSUE_STATS_EN
        .stat_dual(stat_dual), .stat_single(stat_single),
`endif
        .count(count)
    );

    dual_issue_queue #(.DEPTH(8), .DUAL_ISSUE(0)) dut_s (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .stall(stall), .flush(flush),
        .slot0_valid(slot0_valid_s), .slot0_instr(slot0_instr_s),
        .slot1_valid(slot1_valid_s), .slot1_instr(slot1_instr_s),
`ifdef ISSUE_STATS_EN
        .stat_dual(stat_dual_s), .stat_single(stat_single_s),
`endif
        .count(count_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
        in_instr = 32'h0;
    endtask

    // addi rd=(k%31)+1, rs1=x0, imm=k: consecutive values never conflict
    function automatic logic [31:0] mk(input int k);
        return (32'(k) << 20) | (32'((k % 31) + 1) << 7) | 32'h13;
    endfunction

    initial begin
        logic [31:0] q[$];
        logic [31:0] e0, e1;
        int          n, pre;

        n_rst = 1'b0; in_valid = 1'b0; in_instr = 32'h0; stall = 1'b0; flush = 1'b0;
        #12 n_rst = 1'b1;
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_s0v", 32'(slot0_valid), 32'd0);
        chk("rst_s1v", 32'(slot1_valid), 32'd0);
        chk("rst_s0i", slot0_instr, 32'h0);

        // zero word accepted but discarded
        stall = 1'b1;
        push(32'h0);
        chk("zero_discard", 32'(count), 32'd0);

        // dual issue
        push(32'h00500093);
        push(32'h00700113);
        chk("dual_cnt2", 32'(count), 32'd2);
        stall = 1'b0;
        step();
        chk("dual_s0i", slot0_instr, 32'h00500093);
        chk("dual_s0v", 32'(slot0_valid), 32'd1);
        chk("dual_s1i", slot1_instr, 32'h00700113);
        chk("dual_s1v", 32'(slot1_valid), 32'd1);
        chk("dual_cnt0", 32'(count), 32'd0);
        chk("si_dual_s0i", slot0_instr_s, 32'h00500093);
        chk("si_dual_s1v", 32'(slot1_valid_s), 32'd0);
        step();
        chk("dual_idle_s0v", 32'(slot0_valid), 32'd0);
        chk("dual_idle_s0i", slot0_instr, 32'h0);
        chk("si_dual_s0i2", slot0_instr_s, 32'h00700113);

        // RAW hazard
        stall = 1'b1;
        push(32'h00500093);
        push(32'h001081b3);
        stall = 1'b0;
        step();
        chk("raw_s0i", slot0_instr, 32'h00500093);
        chk("raw_s1v", 32'(slot1_valid), 32'd0);
        chk("raw_cnt1", 32'(count), 32'd1);
        step();
        chk("raw_s0i2", slot0_instr, 32'h001081b3);
        chk("raw_s1v2", 32'(slot1_valid), 32'd0);

        // WAW hazard
        stall = 1'b1;
        push(32'h00500093);
        push(32'h00600093);
        stall = 1'b0;
        step();
        chk("waw_s1v", 32'(slot1_valid), 32'd0);
        step();
        chk("waw_s0i2", slot0_instr, 32'h00600093);

        // control-flow head
        stall = 1'b1;
        push(32'h00000463);
        push(32'h00700113);
        stall = 1'b0;
        step();
        chk("ctl_s0i", slot0_instr, 32'h00000463);
        chk("ctl_s1v", 32'(slot1_valid), 32'd0);
        chk("si_ctl_s1v", 32'(slot1_valid_s), 32'd0);
        step();
        chk("ctl_s0i2", slot0_instr, 32'h00700113);
        chk("ctl_s1v2", 32'(slot1_valid), 32'd0);
        step();

        // full, then drain with concurrent pushes across the wrap
        stall = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            push(mk(k));
            q.push_back(mk(k));
        end
        chk("full_cnt", 32'(count), 32'd8);
        chk("full_ready", 32'(in_ready), 32'd0);
        push(mk(9));
        chk("full_9th_ignored", 32'(count), 32'd8);
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5);
            in_instr = (i < 5) ? mk(10 + i) : 32'h0;
            pre = q.size();
            n  = (pre >= 2) ? 2 : pre;
            e0 = (n >= 1) ? q.pop_front() : 32'h0;
            e1 = (n == 2) ? q.pop_front() : 32'h0;
            if (in_valid && pre != 8) q.push_back(in_instr);
            step();
            chk($sformatf("drain%0d_s0i", i), slot0_instr, e0);
            chk($sformatf("drain%0d_s1i", i), slot1_instr, e1);
            chk($sformatf("drain%0d_cnt", i), 32'(count), 32'(q.size()));
            chk($sformatf("si_drain%0d_s1v", i), 32'(slot1_valid_s), 32'd0);
        end
        in_valid = 1'b0;
        in_instr = 32'h0;

        // flush beats push and leaves everything empty
        stall = 1'b1;
        for (int k = 20; k <= 26; k++) push(mk(k));
        stall = 1'b0;
        step();
        chk("fl_pre_s0i", slot0_instr, mk(20));
        chk("fl_pre_s1i", slot1_instr, mk(21));
        chk("fl_pre_cnt", 32'(count), 32'd5);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(30);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'h0;
        chk("fl_cnt", 32'(count), 32'd0);
        chk("fl_s0v", 32'(slot0_valid), 32'd0);
        chk("fl_s1v", 32'(slot1_valid), 32'd0);
        chk("fl_s0i", slot0_instr, 32'h0);
        chk("si_fl_cnt", 32'(count_s), 32'd0);
        step();
        chk("fl_after_s0v", 32'(slot0_valid), 32'd0);
        push(mk(31));
        step();
        chk("fl_next_s0i", slot0_instr, mk(31));
        chk("fl_next_s1v", 32'(slot1_valid), 32'd0);
        chk("si_fl_next_s0i", slot0_instr_s, mk(31));

        // asynchronous reset mid-run
        stall = 1'b1;
        push(mk(40));
        push(mk(41));
        push(mk(42));
        stall = 1'b0;
        step();
        chk("pre_rst_s0v", 32'(slot0_valid), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_s0v", 32'(slot0_valid), 32'd0);
        chk("arst_s1v", 32'(slot1_valid), 32'd0);
        chk("arst_s0i", slot0_instr, 32'h0);
        #3 n_rst = 1'b1;
        step();
        chk("post_rst_s0v", 32'(slot0_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dual_issue_queue.md
Name: dual_issue_queue

Overview:
- Parametrised instruction queue with dual-issue pairing logic. It is the successor to the fixed two-slot instruction cache plus scheduling-assistant pair.
- Buffers RV32 instructions in a DEPTH-entry circular FIFO and selects up to two per cycle into registered issue slots.
- Slot 1 is held back when it depends on slot 0 or when slot 0 is control flow.
- Feeds the two ALU datapaths and the dual-write register file.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 4.
- DUAL_ISSUE, 1, 1 = pair instructions into slot 1; 0 = single-issue mode, slot1_valid always 0.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  core clock.
- n_rst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_instr presented.
- in_ready  output  1  queue can accept a push this cycle.
- in_instr  input  32  instruction to enqueue.
- stall  input  1  downstream hold; slots and queue head frozen.
- flush  input  1  discard all queued and issued instructions.
- slot0_valid  output  1  slot0_instr is live.
- slot0_instr  output  32  older issued instruction.
- slot1_valid  output  1  slot1_instr is live.
- slot1_instr  output  32  younger issued instruction.
- count  output  CNT_W  entries currently in the queue, excluding the slots.

Behaviour:
- Reset (async, n_rst=0): head, tail and count go to 0. slot0_valid=0, slot1_valid=0, both slot instrs=0. in_ready=1.
- in_ready = (count != DEPTH). Combinational, and does not credit same-cycle pops.
- Push: on an edge with in_valid && in_ready, in_instr is written at tail and tail advances, wrapping at DEPTH.
  - in_instr == 32'h0 is accepted but discarded: no write, count unchanged.
- Selection runs combinationally on the queue contents before the edge.
  - A = head entry; B = head+1 entry (modulo DEPTH).
  - issue0 = count >= 1.
  - issue1 = DUAL_ISSUE && count >= 2 && !ctrl(A) && !dep(A,B).
- Decode fields: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- writes(X): opcode is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and rd != 0.
- uses_rs1(X): opcode is one of 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- uses_rs2(X): opcode is one of 0110011, 0100011, 1100011.
- ctrl(X): opcode is one of 1100011, 1101111, 1100111.
- dep(A,B): writes(A) && any of the following hold:
  - uses_rs1(B) && rs1(B) == rd(A) (RAW);
  - uses_rs2(B) && rs2(B) == rd(A) (RAW);
  - writes(B) && rd(B) == rd(A) (WAW).
- Issue edge (stall=0, flush=0):
  - slot0 <= A, valid=issue0; slot1 <= B, valid=issue1.
  - Invalid slots load instr 0.
  - Head advances by issue0+issue1.
- stall=1: slots hold their values, head holds, pushes still accepted.
- count' = count + push − pops. Simultaneous push and pop are allowed. A push when count == DEPTH is ignored.
- flush=1: on that edge head=tail=count=0 and both slots are invalid with instr 0.
  - Flush has priority over push and stall; a same-cycle push is dropped.
- Latency: an instruction pushed at edge E is selectable for edge E+1, so the earliest slot0_valid=1 is the cycle after E+1.
- Program order is always preserved: slot0 is older than slot1, and B never issues without A.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro ISSUE_STATS_EN.
- When defined, add output ports stat_dual [31:0] and stat_single [31:0].
  - stat_dual increments on each issue edge with issue0 && issue1.
  - stat_single increments on each issue edge with issue0 && !issue1.
  - Both counters wrap at 2^32, clear on reset, and are unaffected by flush.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset: pulse n_rst low mid-run → count=0, in_ready=1, slot0_valid=slot1_valid=0 immediately.
- Dual issue: stall=1, push 0x00500093 then 0x00700113, release stall → on one edge slot0=0x00500093, slot1=0x00700113, both valid, count 2→0.
- RAW hazard: stall=1, push 0x00500093 then 0x001081b3, release stall → first edge slot0=0x00500093 with slot1_valid=0. Next edge slot0=0x001081b3.
- Control head: queue holds 0x00000463 followed by 0x00700113 → first edge single-issue of the beq, next edge the addi. With DUAL_ISSUE=0, slot1_valid never asserts.
- Full/wrap: stall=1, push 8 non-zero instrs → count=8, in_ready=0, 9th push ignored. Release stall, then push while draining → FIFO order preserved across wrap.
- Flush: flush=1 with in_valid=1, count=5, slots valid → next cycle count=0, slots invalid. Pushed instr absent from later issue.
